// File: rtl/speed_pwm_if.sv
// Bundle between the speed FSM and the speed-ramp/PWM stage.
// The speed FSM side uses the master modport; the speed_pwm block uses the slave modport.
interface speed_pwm_if;
   logic [3:0] speed;
   logic       en;
   logic       pwm_out;
   logic [3:0] level;
   logic       at_target;
   logic       period_end;

   modport master (
      output speed, en,
      input  pwm_out, level, at_target, period_end
   );

   modport slave (
      input  speed, en,
      output pwm_out, level, at_target, period_end
   );
endinterface

// File: rtl/speed_pwm.sv
// Slew-limited speed level driving a 15-slot glitch-free PWM output.
// Duty is only re-latched at period end, so every period is a whole N/15 pulse.
module speed_pwm #(
   parameter int unsigned RAMP_DIV  = 8,
   parameter int unsigned PWM_SLOTS = 15
) (
   input logic        clk,
   input logic        reset,
   speed_pwm_if.slave bus
);

   localparam logic [7:0] RAMP_LAST = 8'(RAMP_DIV - 1);
   localparam logic [3:0] SLOT_LAST = 4'(PWM_SLOTS - 1);

   logic [7:0] ramp_cnt_q;
   logic [7:0] ramp_cnt_d;
   logic [3:0] level_q;
   logic [3:0] level_d;
   logic [3:0] pwm_cnt_q;
   logic [3:0] pwm_cnt_d;
   logic [3:0] duty_q;
   logic [3:0] duty_d;
   logic [3:0] tgt_s;
   logic       tick_s;
   logic       period_end_s;

   // Effective target and the two per-cycle strobes.
   always_comb begin
      tgt_s = 4'd0;
      if (bus.en) begin
         tgt_s = bus.speed;
      end else begin
         tgt_s = 4'd0;
      end
      tick_s       = (ramp_cnt_q == RAMP_LAST);
      period_end_s = (pwm_cnt_q == SLOT_LAST);
   end

   // Next-state: free-running prescaler, one-step ramp, PWM slot counter and duty latch.
   always_comb begin
      ramp_cnt_d = ramp_cnt_q;
      level_d    = level_q;
      pwm_cnt_d  = pwm_cnt_q;
      duty_d     = duty_q;

      if (tick_s) begin
         ramp_cnt_d = 8'd0;
         if (level_q < tgt_s) begin
            level_d = level_q + 4'd1;
         end else if (level_q > tgt_s) begin
            level_d = level_q - 4'd1;
         end else begin
            level_d = level_q;
         end
      end else begin
         ramp_cnt_d = ramp_cnt_q + 8'd1;
      end

      // duty takes the registered (pre-tick) level even when a tick lands on the same edge
      if (period_end_s) begin
         pwm_cnt_d = 4'd0;
         duty_d    = level_q;
      end else begin
         pwm_cnt_d = pwm_cnt_q + 4'd1;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ramp_cnt_q <= 8'd0;
         level_q    <= 4'd0;
         pwm_cnt_q  <= 4'd0;
         duty_q     <= 4'd0;
      end else begin
         ramp_cnt_q <= ramp_cnt_d;
         level_q    <= level_d;
         pwm_cnt_q  <= pwm_cnt_d;
         duty_q     <= duty_d;
      end
   end

   assign bus.pwm_out    = (pwm_cnt_q < duty_q);
   assign bus.level      = level_q;
   assign bus.at_target  = (level_q == tgt_s);
   assign bus.period_end = period_end_s & reset;

endmodule

// File: tb/tb_speed_pwm.sv
// Scoreboard bench for speed_pwm: stimulus queues the expected duty of each PWM period,
// a negedge monitor rebuilds each period's waveform and checks it at period_end.
module tb_speed_pwm;

   logic clk;
   logic reset;
   int   total;
   int   bad;
   int   cyc;
   int   exp_q[$];

   speed_pwm_if bus ();

   speed_pwm #(.RAMP_DIV(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int expv);
      total = total + 1;
      if (act != expv) begin
         bad = bad + 1;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, expv, cyc);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b1;
      cyc = 0;
   endtask

   // cyc = number of rising edges seen since reset release; sample 1 time unit after the edge
   task automatic run_to(input int n);
      while (cyc < n) begin
         @(posedge clk);
         cyc = cyc + 1;
      end
      #1;
   endtask

   task automatic push_list(input int n, input int v0, input int v1, input int v2,
                            input int v3, input int v4, input int v5, input int v6);
      int vals[7];
      vals = '{v0, v1, v2, v3, v4, v5, v6};
      for (int i = 0; i < n; i++) exp_q.push_back(vals[i]);
   endtask

   // Monitor: period waveform against scoreboard, period_end placement, single-step level moves.
   int          slot;
   logic [14:0] pat;
   logic [3:0]  prev_lvl;
   logic        have_prev;
   always @(negedge clk) begin
      int          e;
      int          d;
      logic [15:0] full;
      if (!reset) begin
         slot      = 0;
         pat       = 15'd0;
         have_prev = 1'b0;
      end else begin
         pat[slot] = bus.pwm_out;
         if (have_prev && (bus.level != prev_lvl)) begin
            d = int'(bus.level) - int'(prev_lvl);
            total = total + 1;
            if (d != 1 && d != -1) begin
               bad = bad + 1;
               $display("FAIL level_step: %0d -> %0d", prev_lvl, bus.level);
            end
         end
         prev_lvl  = bus.level;
         have_prev = 1'b1;
         if (bus.period_end) begin
            total = total + 1;
            if (slot != 14) begin
               bad = bad + 1;
               $display("FAIL period_end_slot: got slot %0d expected 14", slot);
            end
            if (exp_q.size() > 0) begin
               e    = exp_q.pop_front();
               full = (16'd1 << e) - 16'd1;
               total = total + 1;
               if (pat != full[14:0]) begin
                  bad = bad + 1;
                  $display("FAIL period_shape: got %b expected %b (duty %0d)", pat, full[14:0], e);
               end
            end
            slot = 0;
            pat  = 15'd0;
         end else if (slot >= 14) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL period_end_missing: no strobe after 15 slots");
            slot = 0;
            pat  = 15'd0;
         end else begin
            slot = slot + 1;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

   initial begin
      total = 0;
      bad = 0;
      cyc = 0;
      reset = 1'b0;
      bus.speed = 4'd0;
      bus.en = 1'b1;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pwm_out", int'(bus.pwm_out), 0);
      chk("rst_level", int'(bus.level), 0);
      chk("rst_period_end", int'(bus.period_end), 0);
      chk("rst_at_target_tgt0", int'(bus.at_target), 1);
      bus.speed = 4'd15;
      #1;
      chk("rst_at_target_tgt15", int'(bus.at_target), 0);

      // 1: ramp 0 -> 15, duty per period = pre-edge level at each period end
      do_reset();
      push_list(7, 0, 1, 3, 5, 7, 9, 11);
      push_list(4, 13, 14, 15, 15, 0, 0, 0);
      run_to(7);   chk("t1_lvl_c7", int'(bus.level), 0);
      run_to(8);   chk("t1_lvl_c8", int'(bus.level), 1);
      run_to(119); chk("t1_lvl_c119", int'(bus.level), 14);
      chk("t1_at_c119", int'(bus.at_target), 0);
      run_to(120); chk("t1_lvl_c120", int'(bus.level), 15);
      chk("t1_at_c120", int'(bus.at_target), 1);
      run_to(165); chk("t1_drain", exp_q.size(), 0);

      // 2: steady level 5, then 3: speed -> 9 during slot 3 of a 5/15 period
      bus.speed = 4'd5;
      do_reset();
      push_list(6, 0, 1, 3, 5, 5, 5, 0);
      run_to(40);  chk("t2_lvl_c40", int'(bus.level), 5);
      chk("t2_at_c40", int'(bus.at_target), 1);
      run_to(90);  chk("t2_drain", exp_q.size(), 0);
      push_list(5, 5, 7, 8, 9, 9, 0, 0);
      run_to(93);
      bus.speed = 4'd9;
      #1;
      chk("t3_at_drop", int'(bus.at_target), 0);
      run_to(120); chk("t3_lvl_c120", int'(bus.level), 9);
      chk("t3_at_c120", int'(bus.at_target), 1);
      run_to(165); chk("t3_drain", exp_q.size(), 0);

      // 4: level 10, en dropped -> ramp down, then re-enable
      bus.speed = 4'd10;
      bus.en = 1'b1;
      do_reset();
      push_list(7, 0, 1, 3, 5, 7, 9, 9);
      push_list(7, 7, 6, 4, 2, 0, 2, 4);
      run_to(80);  chk("t4_lvl_c80", int'(bus.level), 10);
      bus.en = 1'b0;
      #1;
      chk("t4_at_en0", int'(bus.at_target), 0);
      run_to(88);  chk("t4_lvl_c88", int'(bus.level), 9);
      run_to(159); chk("t4_lvl_c159", int'(bus.level), 1);
      chk("t4_at_c159", int'(bus.at_target), 0);
      run_to(160); chk("t4_lvl_c160", int'(bus.level), 0);
      chk("t4_at_c160", int'(bus.at_target), 1);
      bus.en = 1'b1;
      run_to(200); chk("t4_lvl_c200", int'(bus.level), 5);
      run_to(210); chk("t4_drain", exp_q.size(), 0);

      // 5: level 12 ramping to 0, reversed at level 7
      bus.speed = 4'd12;
      do_reset();
      push_list(7, 0, 1, 3, 5, 7, 9, 11);
      push_list(6, 11, 10, 8, 8, 10, 12, 0);
      run_to(96);  chk("t5_lvl_c96", int'(bus.level), 12);
      bus.speed = 4'd0;
      run_to(136); chk("t5_lvl_c136", int'(bus.level), 7);
      bus.speed = 4'd12;
      run_to(143); chk("t5_lvl_c143", int'(bus.level), 7);
      run_to(144); chk("t5_lvl_c144", int'(bus.level), 8);
      run_to(176); chk("t5_lvl_c176", int'(bus.level), 12);
      chk("t5_at_c176", int'(bus.at_target), 1);
      run_to(195); chk("t5_drain", exp_q.size(), 0);

      // 6: async reset between edges at level 11 with pwm_out high
      bus.speed = 4'd15;
      do_reset();
      push_list(6, 0, 1, 3, 5, 7, 9, 0);
      run_to(92);
      chk("t6_lvl_pre", int'(bus.level), 11);
      chk("t6_pwm_pre", int'(bus.pwm_out), 1);
      chk("t6_drain_pre", exp_q.size(), 0);
      #2;
      reset = 1'b0;
      #1;
      chk("t6_pwm_async", int'(bus.pwm_out), 0);
      chk("t6_lvl_async", int'(bus.level), 0);
      chk("t6_pe_async", int'(bus.period_end), 0);
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b1;
      cyc = 0;
      push_list(2, 0, 1, 0, 0, 0, 0, 0);
      run_to(0);   chk("t6_pwm_rel", int'(bus.pwm_out), 0);
      run_to(13);  chk("t6_pe_c13", int'(bus.period_end), 0);
      run_to(14);  chk("t6_pe_c14", int'(bus.period_end), 1);
      run_to(30);  chk("t6_drain", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
